// File: rtl/nonce_sched_pkg.sv
// Shared types and default widths for the nonce scheduler and its helpers.
package nonce_sched_pkg;

  localparam int NONCE_W_DEF      = 32;
  localparam int BOUNTY_W_DEF     = 24;
  localparam int IDX_W_DEF        = 2;
  localparam int MAX_INFLIGHT_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_REPORT,
    S_DONE
  } state_t;

endpackage

// File: rtl/nonce_gen.sv
// Next-nonce counter for one work entry. It advances on each accepted core
// request and raises a sticky exhausted flag once the limit nonce has been
// issued, so an all-ones limit never wraps back to zero.
module nonce_gen
  import nonce_sched_pkg::*;
#(
  parameter int NONCE_W = NONCE_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               adv,
  input  logic [NONCE_W-1:0] limit,
  output logic [NONCE_W-1:0] nonce,
  output logic               exhausted
);

  // Counter and exhausted flag; load restarts the entry at nonce 0.
  // NOTE: reset is synchronous, so it is just the highest-priority branch
  // inside the clocked block rather than part of the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      nonce     <= '0;
      exhausted <= 1'b0;
    end else if (adv && !exhausted) begin
      if (nonce == limit) begin
        exhausted <= 1'b1;
      end else begin
        nonce <= nonce + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nonce_scheduler.sv
// Sequences one pipelined hash core over up to four work entries, stops an
// entry on its first hash below target, drains outstanding requests and
// reports one result per entry downstream.
module nonce_scheduler
  import nonce_sched_pkg::*;
#(
  parameter int NONCE_W      = NONCE_W_DEF,
  parameter int BOUNTY_W     = BOUNTY_W_DEF,
  parameter int IDX_W        = IDX_W_DEF,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [IDX_W-1:0]    num_entradas,
  input  logic [7:0]          target,
  input  logic [NONCE_W-1:0]  nonce_limit,
  output logic [IDX_W-1:0]    ent_idx,
  input  logic [BOUNTY_W-1:0] ent_bounty,
  output logic                core_valid,
  input  logic                core_ready,
  output logic [BOUNTY_W-1:0] core_bounty,
  output logic [NONCE_W-1:0]  core_nonce,
  input  logic                rsp_valid,
  input  logic [NONCE_W-1:0]  rsp_nonce,
  input  logic [7:0]          rsp_hash_msb,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [IDX_W-1:0]    res_idx,
  output logic [NONCE_W-1:0]  res_nonce,
  output logic [BOUNTY_W-1:0] res_bounty,
  output logic                res_found,
  output logic                busy,
  output logic                fin
);

  localparam int               CNT_W   = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    cfg_num;
  logic [7:0]          cfg_target;
  logic [NONCE_W-1:0]  cfg_limit;
  logic [CNT_W-1:0]    inflight;
  logic [NONCE_W-1:0]  next_nonce;
  logic                exhausted;
  logic                issue_hs, rsp_hit, start_ok, res_hs, next_entry, gen_load;

  assign issue_hs   = core_valid && core_ready;
  assign rsp_hit    = rsp_valid && (rsp_hash_msb < cfg_target);
  assign start_ok   = start && (state == S_IDLE || state == S_DONE);
  assign res_hs     = res_valid && res_ready;
  assign next_entry = (state == S_REPORT) && res_hs && (ent_idx != cfg_num);
  assign gen_load   = start_ok || next_entry;
  assign res_idx    = ent_idx;

  nonce_gen #(.NONCE_W(NONCE_W)) u_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (gen_load),
    .adv       (issue_hs),
    .limit     (cfg_limit),
    .nonce     (next_nonce),
    .exhausted (exhausted)
  );

  // Next-state decode and Moore outputs of the entry sequencer.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt   = state;
    core_valid  = 1'b0;
    core_bounty = '0;
    core_nonce  = '0;
    res_valid   = 1'b0;
    busy        = 1'b0;
    fin         = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        fin = (state == S_DONE);
        if (start) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        busy        = 1'b1;
        core_valid  = (inflight < MAX_CNT) && !exhausted;
        core_bounty = ent_bounty;
        core_nonce  = next_nonce;
        if (rsp_hit) state_nxt = S_DRAIN;
        else if (exhausted && inflight == '0) state_nxt = S_REPORT;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (inflight == '0) state_nxt = S_REPORT;
      end
      S_REPORT: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_hs) state_nxt = (ent_idx == cfg_num) ? S_DONE : S_ISSUE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, configuration, in-flight count and result registers.
  // NOTE: all state updates use non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ent_idx    <= '0;
      cfg_num    <= '0;
      cfg_target <= '0;
      cfg_limit  <= '0;
      inflight   <= '0;
      res_nonce  <= '0;
      res_bounty <= '0;
      res_found  <= 1'b0;
    end else begin
      state <= state_nxt;

      // A response with nothing outstanding is a protocol error; hold at 0.
      case ({issue_hs, rsp_valid && inflight != '0})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase

      if (start_ok) begin
        cfg_num    <= num_entradas;
        cfg_target <= target;
        cfg_limit  <= nonce_limit;
        ent_idx    <= '0;
        res_found  <= 1'b0;
      end

      // Hits only latch in ISSUE, so responses drained later never overwrite.
      if (state == S_ISSUE && rsp_hit) begin
        res_nonce <= rsp_nonce;
        res_found <= 1'b1;
      end else if (state == S_ISSUE && exhausted && inflight == '0) begin
        res_nonce <= cfg_limit;
        res_found <= 1'b0;
      end

      if (state != S_REPORT && state_nxt == S_REPORT) res_bounty <= ent_bounty;

      if (next_entry) begin
        ent_idx   <= ent_idx + 1'b1;
        res_found <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench for nonce_scheduler: a latency-3 core model with a table of
// hitting nonces, an entry store returning 24'hB00000 + index, and a second
// instance with a 4-bit nonce to exercise the all-ones limit.
module tb_nonce_scheduler;

  localparam int NW = 32;
  localparam int BW = 24;
  localparam int IW = 2;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main instance signals
  logic          start = 1'b0;
  logic [IW-1:0] num_entradas = '0;
  logic [7:0]    target = '0;
  logic [NW-1:0] nonce_limit = '0;
  logic [IW-1:0] ent_idx;
  logic [BW-1:0] ent_bounty;
  logic          core_valid;
  logic          core_ready = 1'b1;
  logic [BW-1:0] core_bounty;
  logic [NW-1:0] core_nonce;
  logic          rsp_valid = 1'b0;
  logic [NW-1:0] rsp_nonce = '0;
  logic [7:0]    rsp_hash_msb = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [IW-1:0] res_idx;
  logic [NW-1:0] res_nonce;
  logic [BW-1:0] res_bounty;
  logic          res_found, busy, fin;

  // Narrow-nonce instance signals
  logic          s_start = 1'b0;
  logic [SW-1:0] s_limit = '0;
  logic [IW-1:0] s_ent_idx;
  logic [BW-1:0] s_ent_bounty;
  logic          s_core_valid;
  logic [BW-1:0] s_core_bounty;
  logic [SW-1:0] s_core_nonce;
  logic          s_rsp_valid = 1'b0;
  logic [SW-1:0] s_rsp_nonce = '0;
  logic          s_res_valid;
  logic          s_res_ready = 1'b0;
  logic [IW-1:0] s_res_idx;
  logic [SW-1:0] s_res_nonce;
  logic [BW-1:0] s_res_bounty;
  logic          s_res_found, s_busy, s_fin;

  assign ent_bounty   = {22'h2C0000, ent_idx};
  assign s_ent_bounty = {22'h0, s_ent_idx};

  nonce_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .num_entradas(num_entradas),
    .target(target), .nonce_limit(nonce_limit), .ent_idx(ent_idx),
    .ent_bounty(ent_bounty), .core_valid(core_valid), .core_ready(core_ready),
    .core_bounty(core_bounty), .core_nonce(core_nonce), .rsp_valid(rsp_valid),
    .rsp_nonce(rsp_nonce), .rsp_hash_msb(rsp_hash_msb), .res_valid(res_valid),
    .res_ready(res_ready), .res_idx(res_idx), .res_nonce(res_nonce),
    .res_bounty(res_bounty), .res_found(res_found), .busy(busy), .fin(fin)
  );

  nonce_scheduler #(.NONCE_W(SW)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .num_entradas(2'd0),
    .target(8'h10), .nonce_limit(s_limit), .ent_idx(s_ent_idx),
    .ent_bounty(s_ent_bounty), .core_valid(s_core_valid), .core_ready(1'b1),
    .core_bounty(s_core_bounty), .core_nonce(s_core_nonce), .rsp_valid(s_rsp_valid),
    .rsp_nonce(s_rsp_nonce), .rsp_hash_msb(8'hF0), .res_valid(s_res_valid),
    .res_ready(s_res_ready), .res_idx(s_res_idx), .res_nonce(s_res_nonce),
    .res_bounty(s_res_bounty), .res_found(s_res_found), .busy(s_busy), .fin(s_fin)
  );

  // Core model: accepted request answers three edges later, in order.
  logic [1:0]    pv = '0;
  logic [NW-1:0] pn0 = '0, pn1 = '0;
  logic [NW-1:0] hit0 = 32'hFFFF_FFF0, hit1 = 32'hFFFF_FFF0;
  int            issues = 0;
  int            outst = 0;
  always @(posedge clk) begin
    if (reset) begin
      pv <= '0; rsp_valid <= 1'b0; rsp_nonce <= '0; rsp_hash_msb <= '0; outst <= 0;
    end else begin
      pv           <= {pv[0], core_valid && core_ready};
      pn0          <= core_nonce;
      pn1          <= pn0;
      rsp_valid    <= pv[1];
      rsp_nonce    <= pn1;
      rsp_hash_msb <= (pn1 == hit0 || pn1 == hit1) ? 8'h05 : 8'hF0;
      if (core_valid && core_ready) issues <= issues + 1;
      outst <= outst + int'(core_valid && core_ready) - int'(rsp_valid);
    end
  end

  // Same core model for the narrow instance; it never hits.
  logic [1:0]    s_pv = '0;
  logic [SW-1:0] s_pn0 = '0, s_pn1 = '0, s_last = '0;
  int            s_issues = 0;
  always @(posedge clk) begin
    if (reset) begin
      s_pv <= '0; s_rsp_valid <= 1'b0; s_rsp_nonce <= '0;
    end else begin
      s_pv        <= {s_pv[0], s_core_valid};
      s_pn0       <= s_core_nonce;
      s_pn1       <= s_pn0;
      s_rsp_valid <= s_pv[1];
      s_rsp_nonce <= s_pn1;
      if (s_core_valid) begin
        s_issues <= s_issues + 1;
        s_last   <= s_core_nonce;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [IW-1:0] num, input logic [7:0] tgt, input logic [NW-1:0] lim);
    num_entradas = num;
    target       = tgt;
    nonce_limit  = lim;
    start        = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_res(input string tag, input int budget);
    int n = 0;
    while (!res_valid && n < budget) begin
      tick();
      n++;
    end
    check(tag, res_valid, 1);
  endtask

  task automatic take_res();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {core_valid, core_bounty, core_nonce, res_valid, res_idx, res_nonce,
                res_bounty, res_found, busy, fin, ent_idx}, '0);
  endtask

  initial begin
    logic          cv_seen, got_hit, stable;
    logic [NW-1:0] sn;
    logic [BW-1:0] sb;
    logic [IW-1:0] si;
    logic          sf;
    int            base, n;

    // Reset values
    tick(); tick();
    check_all_zero("reset_outputs");
    reset = 1'b0;
    tick();
    check_all_zero("idle_outputs");

    // Single entry, hit on nonce 7, core_valid off from DRAIN onward
    hit0 = 32'd7;
    do_start(2'd0, 8'h10, 32'd100);
    check("t1_valid_after_start", core_valid, 1);
    check("t1_first_req", {busy, ent_idx, core_bounty, core_nonce}, {1'b1, 2'd0, 24'hB00000, 32'd0});
    got_hit = 1'b0;
    n = 0;
    while (!got_hit && n < 40) begin
      tick();
      n++;
      got_hit = rsp_valid && (rsp_hash_msb < 8'h10);
    end
    check("t1_hit_returned", got_hit, 1);
    tick();
    cv_seen = 1'b0;
    n = 0;
    while (!res_valid && n < 40) begin
      cv_seen |= core_valid;
      tick();
      n++;
    end
    check("t1_res_valid", res_valid, 1);
    check("t1_no_issue_in_drain", cv_seen, 0);
    check("t1_drained", outst, 0);
    check("t1_result", {res_idx, res_nonce, res_bounty, res_found}, {2'd0, 32'd7, 24'hB00000, 1'b1});
    take_res();
    check("t1_done", {fin, busy, res_valid}, 3'b100);

    // Hits on consecutive nonces 4 and 5: the first one wins
    hit0 = 32'd4;
    hit1 = 32'd5;
    do_start(2'd0, 8'h10, 32'd100);
    wait_res("t2_res_valid", 40);
    check("t2_drained", outst, 0);
    check("t2_result", {res_nonce, res_found}, {32'd4, 1'b1});
    take_res();

    // No hit, limit 15: sixteen issues, then a not-found report
    hit0 = 32'hFFFF_FFF0;
    hit1 = 32'hFFFF_FFF0;
    base = issues;
    do_start(2'd0, 8'h10, 32'd15);
    wait_res("t3_res_valid", 80);
    check("t3_issue_count", issues - base, 16);
    check("t3_result", {res_idx, res_nonce, res_found}, {2'd0, 32'd15, 1'b0});
    check("t3_drained", outst, 0);
    take_res();

    // Four entries, result stalled 5 cycles each, start pulsed while busy
    do_start(2'd3, 8'h10, 32'd3);
    for (int e = 0; e < 4; e++) begin
      wait_res("t5_res_valid", 40);
      sn = res_nonce; sb = res_bounty; si = res_idx; sf = res_found;
      stable = 1'b1;
      for (int k = 0; k < 5; k++) begin
        start = (k == 2);
        num_entradas = (k == 2) ? 2'd0 : 2'd3;
        tick();
        stable &= res_valid && res_nonce == sn && res_bounty == sb && res_idx == si && res_found == sf;
      end
      start = 1'b0;
      num_entradas = 2'd3;
      check("t5_payload_stable", stable, 1);
      check("t5_result", {si, sn, sb, sf}, {2'(e), 32'd3, 24'hB00000 + 24'(e), 1'b0});
      take_res();
      if (e < 3) check("t5_next_entry", {core_valid, ent_idx, core_nonce}, {1'b1, 2'(e + 1), 32'd0});
    end
    check("t5_done", {fin, busy}, 2'b10);

    // Narrow nonce with an all-ones limit: no wrap, exhaustion reported
    base = s_issues;
    s_limit = 4'hF;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    n = 0;
    while (!s_res_valid && n < 60) begin
      tick();
      n++;
    end
    check("t4_res_valid", s_res_valid, 1);
    check("t4_issue_count", s_issues - base, 16);
    check("t4_last_issued", s_last, 4'hF);
    check("t4_result", {s_res_nonce, s_res_found, s_fin}, {4'hF, 1'b0, 1'b0});
    s_res_ready = 1'b1;
    tick();
    s_res_ready = 1'b0;
    check("t4_done", {s_fin, s_core_valid}, 2'b10);

    // Reset with three requests outstanding, then restart from scratch
    do_start(2'd1, 8'h10, 32'd100);
    tick(); tick(); tick();
    check("t6_three_inflight", outst, 3);
    reset = 1'b1;
    tick();
    check_all_zero("t6_reset_outputs");
    reset = 1'b0;
    hit0 = 32'd2;
    do_start(2'd0, 8'h10, 32'd100);
    check("t6_restart", {core_valid, ent_idx, core_nonce}, {1'b1, 2'd0, 32'd0});
    wait_res("t6_res_valid", 40);
    check("t6_result", {res_idx, res_nonce, res_found}, {2'd0, 32'd2, 1'b1});
    take_res();
    check("t6_done", fin, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
